// File: rtl/mcu_pkg.sv
// Shared definitions for the on-chip MCU clients and the SPI front end:
// target indices, hid command codes, SPI front-end state encodings and a
// helper that picks one client's read-back byte out of the packed bus.
package mcu_pkg;

    // Target indices carried in the first byte of every SPI message
    localparam logic [1:0] TGT_SYS = 2'd0;
    localparam logic [1:0] TGT_HID = 2'd1;
    localparam logic [1:0] TGT_OSD = 2'd2;
    localparam logic [1:0] TGT_SDC = 2'd3;

    // Command codes understood by the hid client
    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_KEY    = 8'h01;
    localparam logic [7:0] CMD_MOUSE  = 8'h02;
    localparam logic [7:0] CMD_JOY    = 8'h03;

    // SPI front-end message states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_TARGET  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    // Return byte 'idx' of the packed read-back bus, or 8'h00 when the index
    // does not address an existing client.
    function automatic logic [7:0] sel_byte(input logic [31:0] bytes,
                                            input logic [1:0]  idx,
                                            input int          num_targets);
        logic [7:0] r;
        r = 8'h00;
        if (int'(idx) < num_targets) begin
            case (idx)
                2'd0:    r = bytes[7:0];
                2'd1:    r = bytes[15:8];
                2'd2:    r = bytes[23:16];
                2'd3:    r = bytes[31:24];
                default: r = 8'h00;
            endcase
        end else begin
            r = 8'h00;
        end
        return r;
    endfunction

endpackage

// File: rtl/mcu_spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronised value only.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;
    logic              prev_q;
    logic              prev_d;

    // Next value of the synchroniser chain and of the edge-detect history flop
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_in};
        prev_d  = chain_q[STAGES-1];
    end

    // Synchroniser and history registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_out = chain_q[STAGES-1];
    assign rise     = sync_out & ~prev_q;
    assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/mcu_spi.sv
// SPI mode-0 slave front end for the IO MCU. The first byte of each
// chip-select framed message selects a client; every later byte is handed to
// that client as a one-cycle strobe, and MISO shifts out the client's
// read-back byte MSB first.
module mcu_spi
    import mcu_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_TARGETS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_csn,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        data_out_strobe,
    output logic        data_out_start,
    output logic [7:0]  data_out,
    output logic [1:0]  target,
    input  logic [31:0] data_in
);

    logic       sck_s, sck_rise_s, sck_fall_s;
    logic       csn_s, csn_rise_unused, csn_fall_s;
    logic       mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic       sck_sync_unused;
    logic [7:0] rx_byte_s;

    logic [1:0] state_q,    state_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [1:0] target_q,   target_d;
    logic [7:0] data_out_q, data_out_d;
    logic       strobe_q,   strobe_d;
    logic       start_q,    start_d;
    logic       first_q,    first_d;
    logic       reload_q,   reload_d;
    logic       miso_q,     miso_d;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk      (clk),
        .reset_n  (reset_n),
        .d_in     (spi_sck),
        .sync_out (sck_s),
        .rise     (sck_rise_s),
        .fall     (sck_fall_s)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
        .clk      (clk),
        .reset_n  (reset_n),
        .d_in     (spi_csn),
        .sync_out (csn_s),
        .rise     (csn_rise_unused),
        .fall     (csn_fall_s)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk      (clk),
        .reset_n  (reset_n),
        .d_in     (spi_mosi),
        .sync_out (mosi_s),
        .rise     (mosi_rise_unused),
        .fall     (mosi_fall_unused)
    );

    assign sck_sync_unused = sck_s;

    // Message state machine, bit capture, MISO shifting and strobe generation
    always_comb begin
        rx_byte_s  = {rx_shift_q[6:0], mosi_s};
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        target_d   = target_q;
        data_out_d = data_out_q;
        first_d    = first_q;
        strobe_d   = 1'b0;
        start_d    = 1'b0;
        // Reload one clk after the strobe cycle so the client has had a clk to
        // update its read-back byte in response to the strobe.
        reload_d   = strobe_q;
        miso_d     = tx_shift_q[7];

        if (csn_s) begin
            // Chip select high wins over any sck edge; partial bytes are dropped.
            state_d    = ST_IDLE;
            bit_cnt_d  = 3'd0;
            rx_shift_d = 8'h00;
            first_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (csn_fall_s) begin
                        state_d    = ST_TARGET;
                        bit_cnt_d  = 3'd0;
                        rx_shift_d = 8'h00;
                        tx_shift_d = 8'h00;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_TARGET, ST_PAYLOAD: begin
                    if (reload_q && (state_q == ST_PAYLOAD)) begin
                        tx_shift_d = sel_byte(data_in, target_q, NUM_TARGETS);
                    end else begin
                        tx_shift_d = tx_shift_q;
                    end
                    if (sck_rise_s) begin
                        rx_shift_d = rx_byte_s;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ST_TARGET) begin
                                target_d   = rx_byte_s[1:0];
                                tx_shift_d = sel_byte(data_in, rx_byte_s[1:0], NUM_TARGETS);
                                state_d    = ST_PAYLOAD;
                                first_d    = 1'b1;
                            end else begin
                                data_out_d = rx_byte_s;
                                strobe_d   = 1'b1;
                                start_d    = first_q;
                                first_d    = 1'b0;
                            end
                        end else begin
                            state_d = state_q;
                        end
                    end else if (sck_fall_s && (bit_cnt_q != 3'd0)) begin
                        // The fall after a completed byte does not shift: the
                        // MSB of the next reply byte must stay on the line.
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'h00;
            target_q   <= 2'd0;
            data_out_q <= 8'h00;
            strobe_q   <= 1'b0;
            start_q    <= 1'b0;
            first_q    <= 1'b0;
            reload_q   <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            target_q   <= target_d;
            data_out_q <= data_out_d;
            strobe_q   <= strobe_d;
            start_q    <= start_d;
            first_q    <= first_d;
            reload_q   <= reload_d;
            miso_q     <= miso_d;
        end
    end

    assign spi_miso        = miso_q;
    assign data_out_strobe = strobe_q;
    assign data_out_start  = start_q;
    assign data_out        = data_out_q;
    assign target          = target_q;

endmodule
